clock_divider_mc: RTL

// - Synthesizable multi-channel clock generator; successor to the behavioural testbench clock.
// - Derives CHANNELS divided clocks from the single system clk.
// - Each channel has a run-time divide ratio and high time (duty), plus a per-period tick strobe.
// - Start and stop are glitch-free; the block feeds timers and slow peripherals in the CPU top.

---
 rtl/clock_pkg.sv | 18 +
 rtl/clkdiv_channel.sv | 109 ++++++++++
 rtl/clock_divider_mc.sv | 44 ++++
 3 files changed

// File: rtl/clock_pkg.sv
// Shared types and helpers for the multi-channel clock divider.
package clock_pkg;

  localparam int unsigned MIN_DIV = 2;
  localparam int unsigned CALC_W  = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } clkdiv_state_t;

  // Periods shorter than two cycles cannot produce both a high and a low phase.
  function automatic logic [CALC_W-1:0] clamp_div(input logic [CALC_W-1:0] div);
    return (div < CALC_W'(MIN_DIV)) ? CALC_W'(MIN_DIV) : div;
  endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// One divided-clock channel: period counter, run/drain FSM and shadow divide/high set.
// Optional start phase input when CLKDIV_PHASE_EN is defined.
module clkdiv_channel
  import clock_pkg::*;
#(
  parameter int unsigned DIV_W    = 8,
  parameter int unsigned DEF_DIV  = 10,
  parameter int unsigned DEF_HIGH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic [DIV_W-1:0] high_i,
`ifdef CLKDIV_PHASE_EN
  input  logic [DIV_W-1:0] phase_i,
`endif
  output logic             clk_o,
  output logic             tick_o,
  output logic             busy_o
);

  clkdiv_state_t    state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] sdiv_q, sdiv_d;
  logic [DIV_W-1:0] shigh_q, shigh_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic             busy_q, busy_d;

  logic [DIV_W-1:0] div_cl;
  logic [DIV_W-1:0] start_cnt;
  logic             wrap;

  assign div_cl = DIV_W'(clamp_div(CALC_W'(div_i)));
  assign wrap   = (cnt_q == (sdiv_q - DIV_W'(1)));

`ifdef CLKDIV_PHASE_EN
  assign start_cnt = (phase_i >= div_cl) ? '0 : phase_i;
`else
  assign start_cnt = '0;
`endif

  // Outputs lag the counter by one edge; shadows only change at a period boundary.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sdiv_d  = sdiv_q;
    shigh_d = shigh_q;
    clk_d   = 1'b0;
    tick_d  = 1'b0;
    busy_d  = 1'b0;

    if (state_q != IDLE) begin
      clk_d  = (cnt_q < shigh_q);
      tick_d = (cnt_q == '0);
      busy_d = 1'b1;
      cnt_d  = wrap ? '0 : cnt_q + DIV_W'(1);
      if (wrap) begin
        sdiv_d  = div_cl;
        shigh_d = high_i;
      end
    end

    case (state_q)
      IDLE: begin
        if (en_i) begin
          state_d = RUN;
          cnt_d   = start_cnt;
          sdiv_d  = div_cl;
          shigh_d = high_i;
        end
      end
      RUN: begin
        if (!en_i) state_d = wrap ? IDLE : DRAIN;
      end
      DRAIN: begin
        if (en_i)      state_d = RUN;
        else if (wrap) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sdiv_q  <= DIV_W'(DEF_DIV);
      shigh_q <= DIV_W'(DEF_HIGH);
      clk_q   <= 1'b0;
      tick_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sdiv_q  <= sdiv_d;
      shigh_q <= shigh_d;
      clk_q   <= clk_d;
      tick_q  <= tick_d;
      busy_q  <= busy_d;
    end
  end

  assign clk_o  = clk_q;
  assign tick_o = tick_q;
  assign busy_o = busy_q;

endmodule

// File: rtl/clock_divider_mc.sv
// Multi-channel clock divider: CHANNELS independent clkdiv_channel instances on flattened buses.
// Define CLKDIV_PHASE_EN to add the per-channel phase_i start offset.
module clock_divider_mc
  import clock_pkg::*;
#(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned DIV_W    = 8,
  parameter int unsigned DEF_DIV  = 10,
  parameter int unsigned DEF_HIGH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       en_i,
  input  logic [CHANNELS*DIV_W-1:0] div_i,
  input  logic [CHANNELS*DIV_W-1:0] high_i,
`ifdef CLKDIV_PHASE_EN
  input  logic [CHANNELS*DIV_W-1:0] phase_i,
`endif
  output logic [CHANNELS-1:0]       clk_o,
  output logic [CHANNELS-1:0]       tick_o,
  output logic [CHANNELS-1:0]       busy_o
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    clkdiv_channel #(
      .DIV_W   (DIV_W),
      .DEF_DIV (DEF_DIV),
      .DEF_HIGH(DEF_HIGH)
    ) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .en_i   (en_i[i]),
      .div_i  (div_i[i*DIV_W +: DIV_W]),
      .high_i (high_i[i*DIV_W +: DIV_W]),
`ifdef CLKDIV_PHASE_EN
      .phase_i(phase_i[i*DIV_W +: DIV_W]),
`endif
      .clk_o  (clk_o[i]),
      .tick_o (tick_o[i]),
      .busy_o (busy_o[i])
    );
  end

endmodule
